// File: rtl/program_memory_fetch.sv
// Program memory with a fetch responder and a sequential boot loader.
// Fetches return a registered word two edges after the request is accepted;
// the boot loader fills memory from address 0 while load_en is held.
module program_memory_fetch #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              fetch_req,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              busy,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic [ADDR_W:0]   load_count,
  output logic              load_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] COUNT_MAX = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    FETCH1,
    FETCH2,
    READY,
    LOAD
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rd_q;
  logic [ADDR_W-1:0] wptr;

  logic can_start;
  logic enter_load;
  logic accept_fetch;
  logic do_write;

  assign can_start    = (state == IDLE) || (state == READY);
  assign enter_load   = can_start && load_en;
  assign accept_fetch = can_start && !load_en && fetch_req;
  // A word on the closing edge (load_en low) is dropped, as is anything under reset.
  assign do_write     = !reset && (state == LOAD) && load_en && load_valid;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; load requests win over fetch requests when idle
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, READY: begin
        if (load_en)        state_next = LOAD;
        else if (fetch_req) state_next = FETCH1;
      end
      FETCH1:  state_next = FETCH2;
      FETCH2:  state_next = READY;
      LOAD:    if (!load_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state == FETCH1) || (state == FETCH2) || (state == LOAD);
  end

  // Memory array: write port for the loader, synchronous read during FETCH1
  always_ff @(posedge clk) begin
    if (do_write)         mem[wptr] <= load_data;
    if (state == FETCH1)  rd_q      <= mem[addr_q];
  end

  // Fetch and load datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      load_count  <= '0;
      load_done   <= 1'b0;
      wptr        <= '0;
    end else begin
      load_done <= 1'b0;
      if (accept_fetch) begin
        addr_q      <= addr;
        instr_valid <= 1'b0;
      end
      if (state == FETCH2) begin
        instr       <= rd_q;
        instr_valid <= 1'b1;
      end
      if (enter_load) begin
        wptr        <= '0;
        load_count  <= '0;
        instr_valid <= 1'b0;
      end
      if (state == LOAD) begin
        if (!load_en) begin
          load_done <= 1'b1;
        end else if (load_valid) begin
          wptr <= wptr + 1'b1;
          if (load_count != COUNT_MAX) load_count <= load_count + 1'b1;
        end
      end
    end
  end

endmodule
